// File: rtl/membus_responder_if.sv
// membus_responder_if: request/response bus between a cache port and the memory responder.
//   i_bus  [65] EN, [64] RW (1=write), [63:32] byte address, [31:0] write data
//   o_bus  [32] ACK, [31:0] read data
//   o_busy high while the responder holds a request
interface membus_responder_if;
   logic [65:0] i_bus;
   logic [32:0] o_bus;
   logic        o_busy;
   modport master (output i_bus, input o_bus, o_busy);
   modport slave (input i_bus, output o_bus, o_busy);
endinterface

// File: rtl/membus_responder.sv
// membus_responder: single-word memory responder with a fixed access latency.
//   Clk  clock, rising edge
//   Rst  asynchronous active-low reset
//   bus  membus_responder_if.slave (i_bus request, o_bus ack+rdata, o_busy)
//   ADDR_BITS  word-address width (2^ADDR_BITS words of 32 bits)
//   LATENCY    cycles from acceptance to acknowledge, 1..15
//   MEMBUS_POSTED_WRITE_EN  when defined, writes update the array on acceptance and ack next cycle
module membus_responder #(
   parameter int ADDR_BITS = 10,
   parameter int LATENCY   = 4
) (
   input logic Clk,
   input logic Rst,
   membus_responder_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
   state_t                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic                   rw_q, rw_d;
   logic [ADDR_BITS-1:0]   idx_q, idx_d;
   logic [31:0]            wdata_q, wdata_d;
   logic [31:0]            rdata_q, rdata_d;
   logic [31:0]            mem [2**ADDR_BITS];
   logic                   mem_we;
   logic [ADDR_BITS-1:0]   mem_wa;
   logic [31:0]            mem_wd;
   logic                   unused_bits;
   // address bits outside the word index alias onto the array
   assign unused_bits = ^{bus.i_bus[63:ADDR_BITS+34], bus.i_bus[33:32]};
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rw_d    = rw_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      mem_we  = 1'b0;
      mem_wa  = idx_q;
      mem_wd  = wdata_q;
      case (state_q)
         IDLE: if (bus.i_bus[65]) begin
            rw_d    = bus.i_bus[64];
            idx_d   = bus.i_bus[ADDR_BITS+33:34];
            wdata_d = bus.i_bus[31:0];
            cnt_d   = 4'(LATENCY - 1);
`ifdef MEMBUS_POSTED_WRITE_EN
            if (bus.i_bus[64]) begin
               mem_we  = 1'b1;
               mem_wa  = idx_d;
               mem_wd  = wdata_d;
               rdata_d = '0;
               state_d = ACK;
            end else begin
               state_d = BUSY;
            end
`else
            state_d = BUSY;
`endif
         end
         BUSY: if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
         end else begin
            mem_we  = rw_q;
            rdata_d = rw_q ? '0 : mem[idx_q];
            state_d = ACK;
         end
         ACK: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // no array update may slip through while reset is held
      mem_we = mem_we & Rst;
   end
   always_ff @(posedge Clk or negedge Rst)
      if (!Rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rw_q    <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rw_q    <= rw_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   // backing array has no reset
   always_ff @(posedge Clk)
      if (mem_we) mem[mem_wa] <= mem_wd;
   assign bus.o_bus  = (state_q == ACK) ? {1'b1, rdata_q} : '0;
   assign bus.o_busy = (state_q != IDLE);
endmodule

// File: tb/tb_membus_responder.sv
// tb_membus_responder: randomized check of three responders (LATENCY 4, 1, 8) against a word-array model.
module tb_membus_responder;
`ifdef MEMBUS_POSTED_WRITE_EN
   localparam bit POSTED = 1'b1;
`else
   localparam bit POSTED = 1'b0;
`endif
   localparam int LAT [3] = '{4, 1, 8};
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [65:0] req [3];
   logic [32:0] rsp [3];
   logic        bsy [3];
   logic [31:0] mdl [3][1024];
   int          checks = 0;
   int          failures = 0;
   always #5 clk = ~clk;
   membus_responder_if bus0 ();
   membus_responder_if bus1 ();
   membus_responder_if bus2 ();
   assign bus0.i_bus = req[0];
   assign bus1.i_bus = req[1];
   assign bus2.i_bus = req[2];
   assign rsp[0] = bus0.o_bus;
   assign rsp[1] = bus1.o_bus;
   assign rsp[2] = bus2.o_bus;
   assign bsy[0] = bus0.o_busy;
   assign bsy[1] = bus1.o_busy;
   assign bsy[2] = bus2.o_busy;
   membus_responder #(.ADDR_BITS(10), .LATENCY(4)) u_l4 (.Clk(clk), .Rst(rst_n), .bus(bus0));
   membus_responder #(.ADDR_BITS(10), .LATENCY(1)) u_l1 (.Clk(clk), .Rst(rst_n), .bus(bus1));
   membus_responder #(.ADDR_BITS(10), .LATENCY(8)) u_l8 (.Clk(clk), .Rst(rst_n), .bus(bus2));
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   // Present one request at the current negedge (DUT idle), wait for its ACK,
   // then step past the ACK so the caller may present the next request at once.
   task automatic txn(input int s, input bit rw, input logic [31:0] a, input logic [31:0] wd, input string tag);
      int idx;
      int exp_lat;
      int j;
      bit quiet;
      logic [31:0] exp_d;
      idx     = int'(a[11:2]);
      exp_lat = (POSTED && rw) ? 0 : LAT[s];
      exp_d   = rw ? 32'h0 : mdl[s][idx];
      quiet   = 1'b1;
      req[s]  = {1'b1, rw, a, wd};
      @(negedge clk);
      check({tag, "_busy"}, 64'(bsy[s]), 64'd1);
      for (j = 0; j < 40; j++) begin
         if (j > 0) @(negedge clk);
         if (rsp[s][32]) break;
         if (rsp[s] != 33'd0) quiet = 1'b0;
         req[s] = {2'($urandom), $urandom, $urandom};
      end
      check({tag, "_lat"}, 64'(j), 64'(exp_lat));
      check({tag, "_data"}, 64'(rsp[s][31:0]), 64'(exp_d));
      check({tag, "_quiet"}, 64'(quiet), 64'd1);
      if (rw) mdl[s][idx] = wd;
      @(negedge clk);
      req[s] = '0;
      check({tag, "_done"}, 64'({bsy[s], rsp[s]}), 64'd0);
   endtask
   function automatic logic [31:0] rnd_addr(input int idx);
      return ($urandom & 32'hFFFF_F003) | (32'(idx) << 2);
   endfunction
   initial begin
      bit bad;
      for (int s = 0; s < 3; s++) req[s] = '0;
      // reset held with a live request: outputs stay quiet
      req[0] = {1'b1, 1'b1, 32'h0000_0000, 32'h1111_2222};
      bad = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         for (int s = 0; s < 3; s++) if (bsy[s] || rsp[s] != 33'd0) bad = 1'b1;
      end
      check("rst_hold", 64'(bad), 64'd0);
      rst_n = 1'b1;
      txn(0, 1'b1, 32'h0000_0000, 32'h1111_2222, "rst_first");
      // preload the first 32 words of every array
      for (int s = 0; s < 3; s++)
         for (int i = 0; i < 32; i++) txn(s, 1'b1, rnd_addr(i), $urandom, "pre");
      // directed: write then read
      txn(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, "wr10");
      txn(0, 1'b0, 32'h0000_0010, 32'h0, "rd10");
      // directed: aliasing
      txn(0, 1'b1, 32'h0000_1004, 32'hA5A5_A5A5, "alias_wr");
      txn(0, 1'b0, 32'h0000_0004, 32'h0, "alias_rd4");
      txn(0, 1'b0, 32'h0000_0007, 32'h0, "alias_rd7");
      // directed: back-to-back reads on the LATENCY=1 instance
      txn(1, 1'b0, 32'h0000_0020, 32'h0, "b2b0");
      txn(1, 1'b0, 32'h0000_0024, 32'h0, "b2b1");
      txn(1, 1'b0, 32'h0000_0028, 32'h0, "b2b2");
      // directed: write then immediate read on the LATENCY=8 instance
      txn(2, 1'b1, 32'h0000_0030, 32'hCAFE_F00D, "l8_wr");
      txn(2, 1'b0, 32'h0000_0030, 32'h0, "l8_rd");
      // directed: reset two cycles into a write discards it (unless posted)
      txn(0, 1'b1, 32'h0000_0040, 32'h0, "pre40");
      req[0] = {1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678};
      @(negedge clk);
      req[0] = '0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_async", 64'({bsy[0], rsp[0]}), 64'd0);
      if (POSTED) mdl[0][16] = 32'h1234_5678;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      txn(0, 1'b0, 32'h0000_0040, 32'h0, "rd40");
      // randomized traffic with random idle gaps
      for (int s = 0; s < 3; s++)
         for (int n = 0; n < 60; n++) begin
            txn(s, 1'($urandom), rnd_addr($urandom_range(0, 31)), $urandom, "rnd");
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
